score_tile_streamer: RTL
========================

SCORE_TILE_STREAMER -- requirements
Module: score_tile_streamer

Interface
REQ-001 The block SHALL expose parameter COLS, default 7, meaning character columns per row of the score panel.
REQ-002 The block SHALL expose parameter ROWS, default 6, meaning character rows of the score panel.
REQ-003 The block SHALL have port CLK, input, 1, single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port START, input, 1, one-cycle request to stream the panel.
REQ-006 The block SHALL have port SCORE, input, 16, four packed BCD digits, most significant digit in [15:12].
REQ-007 The block SHALL have port CHAR_ADDR, output, 6, address to the combinational panel character ROM.
REQ-008 The block SHALL have port CHAR_DATA, input, 8, tile code returned by the ROM in the same cycle.
REQ-009 The block SHALL have port TILE_X, output, 3, column of the presented tile.
REQ-010 The block SHALL have port TILE_Y, output, 3, row of the presented tile.
REQ-011 The block SHALL have port TILE_CODE, output, 8, tile code presented downstream.
REQ-012 The block SHALL have port TILE_VALID, output, 1, tile presented.
REQ-013 The block SHALL have port TILE_READY, input, 1, downstream accepts the tile.
REQ-014 The block SHALL have ports BUSY and DONE, output, 1 each: stream in progress, and a one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, EMIT and FINISH.
REQ-016 IDLE->FETCH on START: latch SCORE into an internal register; clear row and column counters to 0.
REQ-017 In FETCH, CHAR_ADDR SHALL equal row*COLS+col; next cycle the block SHALL register CHAR_DATA (or its substitute) into TILE_CODE and enter EMIT with TILE_VALID=1.
REQ-018 Latency SHALL be exactly one cycle from FETCH to TILE_VALID.
REQ-019 In EMIT, TILE_X, TILE_Y and TILE_CODE SHALL hold stable while TILE_VALID=1 and TILE_READY=0.
REQ-020 A transfer SHALL occur on a cycle with TILE_VALID=1 and TILE_READY=1; col then increments, wrapping to 0 with row+1 at COLS-1.
REQ-021 After a transfer, the block SHALL go to FETCH unless the transferred tile was (ROWS-1, COLS-1), in which case it SHALL go to FINISH.
REQ-022 FINISH SHALL assert DONE for one cycle, then return to IDLE.
REQ-023 BUSY SHALL be 1 in every state except IDLE.
REQ-024 START while BUSY=1 SHALL be ignored and SHALL NOT disturb the latched score.
REQ-025 CHAR_ADDR SHALL stay within 0..ROWS*COLS-1 (0..41 at defaults) and SHALL be 0 in IDLE.
REQ-026 Exactly ROWS*COLS transfers SHALL occur per stream; 42 at defaults.

Reset
REQ-027 RESET_N low SHALL force IDLE, with counters and latched score set to 0, TILE_VALID=0, TILE_CODE=0, TILE_X=0, TILE_Y=0, CHAR_ADDR=0, BUSY=0 and DONE=0.
REQ-028 Reset mid-stream SHALL abandon the stream without a DONE pulse; a new START after release SHALL begin at (0,0).

Configuration
REQ-029 Macro SCORE_OVERLAY_EN: when defined, tiles at row ROWS-1, columns 1..4 SHALL be DIGIT_BASE+digit, taking digits from SCORE[15:12] down to SCORE[3:0].
REQ-030 With SCORE_OVERLAY_EN, leading zero digits SHALL emit 8'h00, except column 4, which SHALL always show its digit.
REQ-031 Without SCORE_OVERLAY_EN, every TILE_CODE SHALL be CHAR_DATA unmodified, and SCORE SHALL be unused.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, DIGIT_BASE (8'h30), PANEL_COLS=7 and PANEL_ROWS=6.
REQ-033 One sub-module, bcd_digit_blank, SHALL compute the overlay code from the latched score and column; there SHALL be no other sub-modules.

Verification
REQ-034 Reset, START, TILE_READY held 1, ROM model attached -> 42 tiles in raster order, (1,1) code 8'h26, (1,5) code 8'h1f; DONE pulses once.
REQ-035 TILE_READY held low 5 cycles on tile (2,3) -> TILE_CODE 8'h22 with X=3, Y=2 held for all 5 cycles; no tile skipped or duplicated.
REQ-036 SCORE_OVERLAY_EN defined, SCORE=16'h0407 -> row 5, columns 1..4 give 8'h00, 8'h34, 8'h30, 8'h37.
REQ-037 SCORE_OVERLAY_EN defined, SCORE=16'h0000 -> row 5, columns 1..4 give 8'h00, 8'h00, 8'h00, 8'h30.
REQ-038 START pulsed again at tile 10 with a different SCORE -> stream continues unaffected; overlay uses the original SCORE.
REQ-039 RESET_N low during tile 20 -> all outputs 0 immediately; no DONE; a following START restarts at CHAR_ADDR 0.

Source files
------------

// File: rtl/score_tile_streamer_pkg.sv
// score_tile_streamer_pkg
//   Shared definitions for the score panel tile streamer:
//   - stream_state_e : streamer FSM states
//   - DIGIT_BASE     : tile code of digit '0' in the panel font
//   - PANEL_COLS/ROWS: default panel geometry (characters)
package score_tile_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EMIT   = 2'd2,
    ST_FINISH = 2'd3
  } stream_state_e;

  localparam logic [7:0] DIGIT_BASE = 8'h30;
  localparam int         PANEL_COLS = 7;
  localparam int         PANEL_ROWS = 6;

endpackage

// File: rtl/score_tile_streamer_bcd_digit_blank.sv
// bcd_digit_blank
//   Maps a panel column to the overlay tile code for the latched 4-digit BCD
//   score. Columns 1..4 show SCORE[15:12] .. SCORE[3:0]; leading zeros are
//   blanked to 8'h00 except the last digit, which always shows.
// Ports:
//   i_score : latched packed BCD score
//   i_col   : panel column being fetched
//   o_hit   : column lies inside the score field (1..4)
//   o_code  : overlay tile code for that column
module bcd_digit_blank
  import score_tile_streamer_pkg::*;
(
  input  logic [15:0] i_score,
  input  logic [2:0]  i_col,
  output logic        o_hit,
  output logic [7:0]  o_code
);

  logic [3:0] w_digit;
  logic       w_blank;

  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    o_hit   = 1'b1;
    case (i_col)
      3'd1: begin
        w_digit = i_score[15:12];
        w_blank = (i_score[15:12] == 4'd0);
      end
      3'd2: begin
        w_digit = i_score[11:8];
        w_blank = (i_score[15:8] == 8'd0);
      end
      3'd3: begin
        w_digit = i_score[7:4];
        w_blank = (i_score[15:4] == 12'd0);
      end
      3'd4: w_digit = i_score[3:0];
      default: o_hit = 1'b0;
    endcase
    o_code = w_blank ? 8'h00 : (DIGIT_BASE + {4'h0, w_digit});
  end

endmodule

// File: rtl/score_tile_streamer.sv
// score_tile_streamer
//   Streams the score panel as ROWS x COLS tiles in raster order. Each tile is
//   read from a combinational character ROM (FETCH) and presented on a
//   valid/ready port on the following cycle (EMIT). DONE pulses once after the
//   last tile is accepted.
//   Optional macro SCORE_OVERLAY_EN: replaces row ROWS-1, columns 1..4 with
//   the BCD score digits latched at START (leading zeros blanked).
// Ports:
//   CLK, RESET_N            : clock, async active-low reset
//   START, SCORE            : stream request and score to latch
//   CHAR_ADDR, CHAR_DATA    : ROM address out, tile code back (same cycle)
//   TILE_X/Y/CODE           : presented tile column, row and code
//   TILE_VALID, TILE_READY  : downstream handshake
//   BUSY, DONE              : stream active, one-cycle completion pulse
module score_tile_streamer
  import score_tile_streamer_pkg::*;
#(
  parameter int COLS = PANEL_COLS,
  parameter int ROWS = PANEL_ROWS
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [15:0] SCORE,
  output logic [5:0]  CHAR_ADDR,
  input  logic [7:0]  CHAR_DATA,
  output logic [2:0]  TILE_X,
  output logic [2:0]  TILE_Y,
  output logic [7:0]  TILE_CODE,
  output logic        TILE_VALID,
  input  logic        TILE_READY,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [2:0] COL_LAST = 3'(COLS - 1);
  localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);

  stream_state_e r_state;
  logic [2:0]    r_col, r_row;
  logic [5:0]    r_addr;
  logic [2:0]    r_x, r_y;
  logic [7:0]    r_code;
  logic          r_valid, r_busy, r_done;
  logic [7:0]    w_code;
  logic          w_last;

  assign w_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

`ifdef SCORE_OVERLAY_EN
  logic [15:0] r_score;
  logic        w_hit;
  logic [7:0]  w_ovl_code;

  bcd_digit_blank u_digit (
    .i_score (r_score),
    .i_col   (r_col),
    .o_hit   (w_hit),
    .o_code  (w_ovl_code)
  );

  assign w_code = (r_row == ROW_LAST && w_hit) ? w_ovl_code : CHAR_DATA;
`else
  logic w_unused_score;
  assign w_unused_score = ^SCORE;
  assign w_code         = CHAR_DATA;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_col   <= 3'd0;
      r_row   <= 3'd0;
      r_addr  <= 6'd0;
      r_x     <= 3'd0;
      r_y     <= 3'd0;
      r_code  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SCORE_OVERLAY_EN
      r_score <= 16'h0000;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // START is only sampled here, so a mid-stream START cannot touch
          // the latched score or counters.
          if (START) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
            r_col   <= 3'd0;
            r_row   <= 3'd0;
            r_addr  <= 6'd0;
`ifdef SCORE_OVERLAY_EN
            r_score <= SCORE;
`endif
          end
        end
        ST_FETCH: begin
          r_code  <= w_code;
          r_x     <= r_col;
          r_y     <= r_row;
          r_valid <= 1'b1;
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (TILE_READY) begin
            r_valid <= 1'b0;
            if (w_last) begin
              // Park address/counters at 0 so CHAR_ADDR never leaves range.
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
              r_col   <= 3'd0;
              r_row   <= 3'd0;
              r_addr  <= 6'd0;
            end else begin
              // Raster order makes row*COLS+col a simple running count.
              r_state <= ST_FETCH;
              r_addr  <= r_addr + 6'd1;
              if (r_col == COL_LAST) begin
                r_col <= 3'd0;
                r_row <= r_row + 3'd1;
              end else begin
                r_col <= r_col + 3'd1;
              end
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign CHAR_ADDR  = r_addr;
  assign TILE_X     = r_x;
  assign TILE_Y     = r_y;
  assign TILE_CODE  = r_code;
  assign TILE_VALID = r_valid;
  assign BUSY       = r_busy;
  assign DONE       = r_done;

endmodule
